// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_queue_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned PC_W        = 32;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO with a synchronous flush. It holds both the list of in-flight fetch PCs and
// the decode-side instruction queue.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW:0]      count_q, count_d;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PW'(1);
            if (pop)  rptr_d = rptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wptr_q] <= wdata;
    end

    assign rdata = mem_q[rptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: issues sequential fetches, queues returned instructions for
// decode, and discards responses belonging to requests issued before a redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [XLEN-1:0] dec_pc_o,
    output logic [31:0]     dec_instr_o
);

    localparam int unsigned CW = $clog2(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW:0]     drop_q, drop_d;
    logic [CW:0]     q_count, outstanding;
    logic [XLEN-1:0] rsp_pc;
    fetch_entry_t    wr_entry, head;
    logic            req_fire, rsp_valid, rsp_keep, pop;

    // Never ask for more than the queue can absorb once everything in flight returns.
    assign imem_req_valid_o = reset_n && !redirect_i &&
                              (32'(q_count) + 32'(outstanding) < DEPTH);
    assign imem_req_addr_o  = fetch_pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    // A response with nothing outstanding belongs to a request abandoned by reset.
    assign rsp_valid = imem_rsp_valid_i && (outstanding != '0);
    assign rsp_keep  = rsp_valid && !redirect_i && (drop_q == '0);
    assign pop       = dec_valid_o && dec_ready_i;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i & ~XLEN'(INSTR_BYTES - 1);
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
        end
    end

    // Everything still in flight at a redirect is stale; a response in that same cycle is
    // already being dropped, so it is not counted again.
    always_comb begin
        drop_d = drop_q;
        if (redirect_i) begin
            drop_d = outstanding - (CW+1)'(rsp_valid);
        end else if (rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - (CW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q <= RESET_PC;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        wr_entry       = '0;
        wr_entry.pc    = PC_W'(rsp_pc);
        wr_entry.instr = imem_rsp_data_i;
    end

    // Every response, kept or dropped, retires its PC so the list stays in request order.
    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN)
    ) u_pc_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (1'b0),
        .push    (req_fire),
        .wdata   (fetch_pc_q),
        .pop     (rsp_valid),
        .rdata   (rsp_pc),
        .count   (outstanding)
    );

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_data_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (redirect_i),
        .push    (rsp_keep),
        .wdata   (wr_entry),
        .pop     (pop),
        .rdata   (head),
        .count   (q_count)
    );

    assign dec_valid_o = (q_count != '0);
    assign dec_pc_o    = XLEN'(head.pc);
    assign dec_instr_o = head.instr;

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC and address width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning fetch-queue entries; power of two, >= 2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0, meaning first fetch address after reset.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port redirect_i, input, 1, branch/jump redirect strobe.
REQ-007 SHALL have port redirect_pc_i, input, XLEN, redirect target.
REQ-008 SHALL have port imem_req_valid_o, output, 1, fetch request valid.
REQ-009 SHALL have port imem_req_ready_i, input, 1, memory accepts request.
REQ-010 SHALL have port imem_req_addr_o, output, XLEN, fetch address.
REQ-011 SHALL have port imem_rsp_valid_i, input, 1, instruction return strobe.
REQ-012 SHALL have port imem_rsp_data_i, input, 32, returned instruction.
REQ-013 SHALL have port dec_valid_o, output, 1, queue head valid to decode.
REQ-014 SHALL have port dec_ready_i, input, 1, decode accepts head; low = stall.
REQ-015 SHALL have port dec_pc_o, output, XLEN, PC of head entry.
REQ-016 SHALL have port dec_instr_o, output, 32, instruction of head entry.

Function
REQ-017 SHALL hold a fetch PC; a request handshake (valid && ready) advances it by 4 in the same edge.
REQ-018 SHALL assert imem_req_valid_o only when count + outstanding < DEPTH and redirect_i is low; imem_req_addr_o = fetch PC.
REQ-019 SHALL track outstanding requests (0..DEPTH); +1 on request handshake, -1 on each response, both in one cycle = unchanged.
REQ-020 SHALL write each non-dropped response into the queue tail as {PC of matching request, imem_rsp_data_i}; responses return in request order, latency >= 1 cycle.
REQ-021 SHALL keep a per-entry PC FIFO of issued addresses so the response PC is exact.
REQ-022 SHALL present the queue head combinationally on dec_*_o; dec_valid_o = (count != 0).
REQ-023 SHALL pop the head on dec_valid_o && dec_ready_i; push and pop in the same cycle leave count unchanged.
REQ-024 SHALL wrap read/write pointers modulo DEPTH; full (count == DEPTH) never pushes because of REQ-018.
REQ-025 On redirect_i, SHALL in one edge: flush queue (count=0), load fetch PC = {redirect_pc_i[XLEN-1:2], 2'b00}, set drop counter = outstanding (minus 1 if a response arrives that same cycle), outstanding = that value.
REQ-026 SHALL discard responses while drop counter > 0, decrementing it and outstanding for each; discarded responses never appear on dec_*_o.
REQ-027 A response coinciding with redirect_i SHALL be discarded; a pop coinciding with redirect_i is consumed and the rest flushed.
REQ-028 Back-to-back redirects SHALL each reload the PC; the last one wins; the drop count accumulates all still-outstanding requests.
REQ-029 dec_ready_i low SHALL hold head entry and all dec_*_o stable.

Reset
REQ-030 On reset_n low, asynchronously: fetch PC = RESET_PC, count = outstanding = drop = 0, pointers = 0, dec_valid_o = 0, imem_req_valid_o = 0.
REQ-031 Reset asserted mid-operation SHALL abandon all in-flight requests; first request after release uses RESET_PC.

Structure
REQ-032 Shared package SHALL hold the fetch-entry struct {pc, instr} and the instruction-size constant (4).
REQ-033 SHALL instantiate one sub-module, fetch_fifo (parametrised DEPTH x entry, flush input), used for both the data queue and the PC FIFO.

Verification
REQ-034 Reset release, ready=1, memory latency 1 -> requests at 0,4,8,..., decode sees pc 0/instr A on cycle 2.
REQ-035 dec_ready_i=0 with DEPTH=4 -> exactly 4 requests issued, then imem_req_valid_o=0; dec_* stable.
REQ-036 Redirect to 0x103 with 2 outstanding -> next request 0x100; 2 returning responses dropped; first dec_pc_o = 0x100.
REQ-037 Redirect in the same cycle as a response and a pop -> response dropped, queue empty next cycle, drop count = outstanding-1.
REQ-038 imem_req_ready_i toggling randomly, latency 1-3 -> dec PC sequence strictly +4, no loss or duplication.
REQ-039 reset_n pulsed low with 3 outstanding -> all outputs zeroed immediately; first post-reset request at RESET_PC.
